// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sizes, header layout and state encodings for the program loader.
package cpu_pkg;
  localparam int DATA_WIDTH = 10;
  localparam int DMEM_WIDTH = 8;
  localparam int MEM_DEPTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int HDR_SEL = DATA_WIDTH - 1;
  localparam int HDR_GO = DATA_WIDTH - 2;
  localparam int HDR_RSV_HI = DATA_WIDTH - 3;
  localparam int HDR_RSV_LO = 2 * ADDR_WIDTH;
  localparam int HDR_CNT_HI = 2 * ADDR_WIDTH - 1;
  localparam int HDR_CNT_LO = ADDR_WIDTH;
  localparam int HDR_BASE_HI = ADDR_WIDTH - 1;
  localparam logic MEM_SEL_INSTR = 1'b0;
  localparam logic MEM_SEL_DATA = 1'b1;
  typedef enum logic [2:0] {L_HDR, L_LOAD, L_START, L_RUN, L_DUMP} ld_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RD, D_WAIT, D_OUT} dump_state_t;
endpackage

// File: rtl/cpu_dump_ctrl.sv
// cpu_dump_ctrl: reads every data-memory word in order and streams it out on a valid/ready port.
module cpu_dump_ctrl
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  out_ready_i,
  input  logic [DMEM_WIDTH-1:0] rdata_i,
  output logic                  active_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  output logic [DMEM_WIDTH-1:0] out_data_o,
  output logic                  done_o
);
  dump_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DMEM_WIDTH-1:0] data_q;
  logic last;
  always_comb begin
    last = idx_q == ADDR_WIDTH'(MEM_DEPTH - 1);
    done_o = state_q == D_OUT && out_ready_i && last;
    state_d = state_q;
    idx_d = idx_q;
    unique case (state_q)
      D_IDLE: if (start_i) begin
        state_d = D_RD;
        idx_d = '0;
      end
      D_RD: state_d = D_WAIT;
      D_WAIT: state_d = D_OUT;
      D_OUT: if (out_ready_i) begin
        state_d = last ? D_IDLE : D_RD;
        idx_d = idx_q + 1'b1;
      end
      default: state_d = D_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= D_IDLE;
      idx_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (state_q == D_WAIT) data_q <= rdata_i;
    end
  end
  assign active_o = state_q != D_IDLE;
  assign addr_o = idx_q;
  assign out_valid_o = state_q == D_OUT;
  assign out_last_o = out_valid_o && last;
  assign out_data_o = data_q;
endmodule

// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: loads framed words into instruction/data memory, starts the core, then dumps data memory.
module cpu_prog_loader
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WIDTH-1:0] dmem_wdata,
  input  logic [DMEM_WIDTH-1:0] dmem_rdata,
  output logic                  mem_own,
  output logic                  cpu_start,
  input  logic                  cpu_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DMEM_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);
  ld_state_t state_q, state_d;
  logic sel_q, sel_d, go_q, go_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, base_q, base_d, beat_q, beat_d, waddr_q, waddr_d;
  logic imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic accept, dump_start, dump_done, dump_active;
  logic [ADDR_WIDTH-1:0] rd_addr;
  assign in_ready = state_q == L_HDR || state_q == L_LOAD;
  always_comb begin
    accept = in_valid && in_ready;
    dump_start = state_q == L_RUN && cpu_done;
    state_d = state_q;
    sel_d = sel_q;
    go_d = go_q;
    cnt_d = cnt_q;
    base_d = base_q;
    beat_d = beat_q;
    err_d = err_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    unique case (state_q)
      L_HDR: if (accept) begin
        if (|in_data[HDR_RSV_HI:HDR_RSV_LO]) err_d = 1'b1;
        else begin
          state_d = L_LOAD;
          sel_d = in_data[HDR_SEL];
          go_d = in_data[HDR_GO];
          cnt_d = in_data[HDR_CNT_HI:HDR_CNT_LO];
          base_d = in_data[HDR_BASE_HI:0];
          beat_d = '0;
        end
      end
      L_LOAD: if (accept) begin
        // address width equals log2(MEM_DEPTH), so the sum wraps past the top word naturally
        imem_we_d = sel_q == MEM_SEL_INSTR;
        dmem_we_d = sel_q == MEM_SEL_DATA;
        waddr_d = base_q + beat_q;
        wdata_d = in_data;
        beat_d = beat_q + 1'b1;
        if (beat_q == cnt_q) state_d = go_q ? L_START : L_HDR;
      end
      L_START: state_d = L_RUN;
      L_RUN: if (cpu_done) state_d = L_DUMP;
      L_DUMP: if (dump_done) state_d = L_HDR;
      default: state_d = L_HDR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= L_HDR;
      sel_q <= 1'b0;
      go_q <= 1'b0;
      cnt_q <= '0;
      base_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      go_q <= go_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      beat_q <= beat_d;
      err_q <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
    end
  end
  cpu_dump_ctrl u_dump (
    .clk         (clk),
    .rst         (rst),
    .start_i     (dump_start),
    .out_ready_i (out_ready),
    .rdata_i     (dmem_rdata),
    .active_o    (dump_active),
    .addr_o      (rd_addr),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_data_o  (out_data),
    .done_o      (dump_done)
  );
  assign imem_we = imem_we_q;
  assign imem_addr = waddr_q;
  assign imem_wdata = wdata_q;
  assign dmem_we = dmem_we_q;
  assign dmem_addr = dump_active ? rd_addr : waddr_q;
  assign dmem_wdata = wdata_q[DMEM_WIDTH-1:0];
  assign mem_own = !(state_q == L_START || state_q == L_RUN);
  assign cpu_start = state_q == L_START;
  assign busy = state_q != L_HDR;
  assign err = err_q;
endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb_cpu_prog_loader: table-driven and random frames against a memory-level model with a stand-in core.
module tb_cpu_prog_loader;
  import cpu_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cpu_done = 1'b0;
  logic [9:0] in_data = '0;
  logic in_ready, imem_we, dmem_we, mem_own, cpu_start, out_valid, out_last, busy, err;
  logic [2:0] imem_addr, dmem_addr;
  logic [9:0] imem_wdata;
  logic [7:0] dmem_wdata, out_data;
  logic [7:0] dmem_rdata = '0;
  cpu_prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_own(mem_own), .cpu_start(cpu_start), .cpu_done(cpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );
  // memories plus a stand-in core that adds imem[i][7:0] into dmem[i] a few cycles after start
  logic [9:0] imem [8] = '{default: '0};
  logic [7:0] dmem [8] = '{default: '0};
  int run_cnt = 0;
  logic [13:0] wlog[$];
  int both_cnt = 0, start_cnt = 0, own_bad = 0;
  always @(posedge clk) begin
    if (imem_we) begin
      imem[imem_addr] <= imem_wdata;
      wlog.push_back({1'b0, imem_addr, imem_wdata});
    end
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      wlog.push_back({1'b1, dmem_addr, 2'b00, dmem_wdata});
    end
    if (imem_we && dmem_we) both_cnt <= both_cnt + 1;
    if (cpu_start) start_cnt <= start_cnt + 1;
    dmem_rdata <= dmem[dmem_addr];
    if (cpu_start) begin
      run_cnt <= 5;
      cpu_done <= 1'b0;
    end else if (run_cnt == 1) begin
      for (int i = 0; i < 8; i++) dmem[i] <= dmem[i] + imem[i][7:0];
      cpu_done <= 1'b1;
      run_cnt <= 0;
      if (mem_own) own_bad <= own_bad + 1;
    end else if (run_cnt != 0) run_cnt <= run_cnt - 1;
  end
  typedef struct {
    logic sel; logic go; int cnt; int base; logic [1:0] rsv; logic [79:0] pl;
    int first_a; int last_a; logic exp_err;
  } vec_t;
  vec_t tbl[5];
  logic [9:0] m_imem [8];
  logic [7:0] m_dmem [8];
  logic m_err;
  logic [13:0] exp_log[$];
  int ptr = 0, checks = 0, failures = 0;
  function automatic logic [79:0] pl8(int a, int b, int c, int d, int e, int f, int g, int h);
    return {10'(h), 10'(g), 10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_reset();
    chk("reset_state", {in_ready, mem_own, busy, err, out_valid, out_last, cpu_start, imem_we, dmem_we,
                        imem_addr, dmem_addr, imem_wdata, dmem_wdata, out_data}, {9'b110000000, 32'd0});
  endtask
  task automatic send_word(input logic [9:0] w, input bit gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic check_log();
    repeat (2) @(posedge clk);
    #1;
    chk("write_count", wlog.size() - ptr, exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      if (ptr + i < wlog.size()) chk("write_entry", wlog[ptr+i], exp_log[i]);
    ptr = wlog.size();
    exp_log.delete();
    chk("we_overlap", both_cnt, 0);
    chk("own_during_core", own_bad, 0);
  endtask
  task automatic do_dump(input int bp_idx, input int bp_len, input bit rnd);
    int t, n;
    logic [7:0] d0;
    logic l0;
    for (int w = 0; w < 8; w++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (!out_valid) begin
        chk("dump_valid", out_valid, 1);
        return;
      end
      n = (w == bp_idx) ? bp_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      d0 = out_data;
      l0 = out_last;
      repeat (n) begin
        @(posedge clk); #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, d0);
        chk("bp_last", out_last, l0);
      end
      chk("dump_data", out_data, m_dmem[w]);
      chk("dump_last", out_last, w == 7);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("dump_end_valid", out_valid, 0);
  endtask
  task automatic send_frame(input vec_t f, input bit gaps, input int bp_idx, input int bp_len, input bit rnd);
    int s0, a;
    logic [9:0] w;
    s0 = start_cnt;
    send_word({f.sel, f.go, f.rsv, 3'(f.cnt - 1), 3'(f.base)}, 1'b0);
    if (f.rsv != 0) m_err = 1'b1;
    else begin
      for (int k = 0; k < f.cnt; k++) begin
        w = f.pl[k*10 +: 10];
        a = (f.base + k) % 8;
        if (f.sel) begin
          m_dmem[a] = w[7:0];
          exp_log.push_back({1'b1, 3'(a), 2'b00, w[7:0]});
        end else begin
          m_imem[a] = w;
          exp_log.push_back({1'b0, 3'(a), w});
        end
        send_word(w, gaps && k < f.cnt - 1 && $urandom_range(0, 1) == 1);
      end
      if (f.go) begin
        chk("cpu_start", cpu_start, 1);
        chk("mem_own_start", mem_own, 0);
        chk("in_ready_start", in_ready, 0);
        for (int i = 0; i < 8; i++) m_dmem[i] = m_dmem[i] + m_imem[i][7:0];
        do_dump(bp_idx, bp_len, rnd);
        chk("start_pulses", start_cnt - s0, 1);
      end
    end
    check_log();
    chk("err", err, m_err);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0;
    vec_t f;
    tbl[0] = '{1'b1, 1'b0, 8, 0, 2'b00, pl8(5, 3, 0, 0, 0, 0, 0, 0), 0, 7, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 3, 6, 2'b00, pl8(1, 2, 3, 0, 0, 0, 0, 0), 6, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8, 0, 2'b00, pl8(10'b0100010000, 10'b0110010100, 10'b1000000101, 10'b1011000110,
                                           10'b1100001011, 10'b1110000000, 10'b1111111110, 10'b0000000000), 0, 7, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1, 0, 2'b01, pl8(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 2, 3, 2'b00, pl8(9, 10, 0, 0, 0, 0, 0, 0), 3, 4, 1'b1};
    for (int i = 0; i < 8; i++) begin
      m_imem[i] = '0;
      m_dmem[i] = '0;
    end
    m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset();
    for (int i = 0; i < 5; i++) begin
      p0 = wlog.size();
      send_frame(tbl[i], i == 4, (i == 2) ? 2 : -1, 5, 1'b0);
      chk("tbl_err", err, tbl[i].exp_err);
      if (tbl[i].rsv == 0 && wlog.size() >= p0 + tbl[i].cnt) begin
        chk("tbl_first_addr", wlog[p0][12:10], tbl[i].first_a);
        chk("tbl_last_addr", wlog[p0+tbl[i].cnt-1][12:10], tbl[i].last_a);
      end
    end
    send_word({1'b0, 1'b0, 2'b00, 3'd3, 3'd2}, 1'b0);
    send_word(10'h155, 1'b0);
    send_word(10'h0aa, 1'b0);
    m_imem[2] = 10'h155;
    m_imem[3] = 10'h0aa;
    exp_log.push_back({1'b0, 3'd2, 10'h155});
    exp_log.push_back({1'b0, 3'd3, 10'h0aa});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_err = 1'b0;
    chk_reset();
    check_log();
    f = '{1'b0, 1'b0, 4, 2, 2'b00, pl8(11, 22, 33, 44, 0, 0, 0, 0), 2, 5, 1'b0};
    send_frame(f, 1'b0, -1, 0, 1'b0);
    repeat (25) begin
      f.sel = 1'($urandom_range(0, 1));
      f.go = $urandom_range(0, 3) == 0;
      f.cnt = $urandom_range(1, 8);
      f.base = $urandom_range(0, 7);
      f.rsv = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int k = 0; k < 8; k++) f.pl[k*10 +: 10] = 10'($urandom);
      send_frame(f, 1'b1, -1, 0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("imem_final", imem[i], m_imem[i]);
      chk("dmem_final", dmem[i], m_dmem[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Upstream front-end of cpu_top. Accepts a valid/ready word stream of load frames and writes them into instruction memory and data memory while the core is idle.
- After a frame flagged "go", it pulses the core's start and waits for done. It then streams all data-memory words out on a valid/ready result port and returns to accepting frames.
- It owns both memories' write and read ports except while the core runs; cpu_top muxes the memory ports on mem_own.

Parameters:
- DATA_WIDTH, 10, instruction width and input stream word width.
- DMEM_WIDTH, 8, data-memory word width.
- MEM_DEPTH, 8, words per memory.
- ADDR_WIDTH, 3, memory address width; DATA_WIDTH >= 2*ADDR_WIDTH+2 is required.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DATA_WIDTH  header or payload word.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_WIDTH  instruction memory write address.
- imem_wdata  out  DATA_WIDTH  instruction memory write data.
- dmem_we  out  1  data memory write strobe.
- dmem_addr  out  ADDR_WIDTH  data memory address (write or read).
- dmem_wdata  out  DMEM_WIDTH  data memory write data.
- dmem_rdata  in  DMEM_WIDTH  data memory read data, 1-cycle synchronous latency.
- mem_own  out  1  1 = loader drives memory ports, 0 = core drives them.
- cpu_start  out  1  one-cycle start pulse to the core.
- cpu_done  in  1  core finished (level, sampled in RUN only).
- out_valid  out  1  dump word valid.
- out_ready  in  1  consumer accepts dump word.
- out_data  out  DMEM_WIDTH  dump word.
- out_last  out  1  marks final dump word (address MEM_DEPTH-1).
- busy  out  1  high in every state except HDR.
- err  out  1  sticky malformed-header flag; cleared only by rst.

Behaviour:
- Header word fields:
  - [DATA_WIDTH-1] sel: 0 = instruction memory, 1 = data memory.
  - [DATA_WIDTH-2] go.
  - [DATA_WIDTH-3 : 2*ADDR_WIDTH] reserved, must be 0.
  - [2*ADDR_WIDTH-1 : ADDR_WIDTH] count-1.
  - [ADDR_WIDTH-1:0] base address.
- Payload: count words follow the header. For data memory, the low DMEM_WIDTH bits are written and upper bits are ignored.
- States:
  - HDR: in_ready=1. On an accepted header with reserved bits nonzero: set err, drop the word, stay in HDR. Otherwise latch sel/go/count/base and go to LOAD.
  - LOAD: in_ready=1. Each accepted beat issues a write. Address = (base + beat index) mod MEM_DEPTH, so writes wrap past MEM_DEPTH-1 to 0. After the count-th beat: go to START if go=1, else HDR.
  - START: in_ready=0, cpu_start=1 for exactly one cycle, mem_own=0; next state RUN.
  - RUN: mem_own=0, in_ready=0. When cpu_done=1, go to DUMP_RD with index 0.
  - DUMP_RD: mem_own=1, dmem_addr=index, dmem_we=0; next state DUMP_WAIT.
  - DUMP_WAIT: capture dmem_rdata into out_data; next state DUMP_OUT.
  - DUMP_OUT: out_valid=1. out_data and out_last are held stable while out_ready=0. On handshake: if index=MEM_DEPTH-1 go to HDR, else increment index and go to DUMP_RD.
- Write-port timing: write outputs are registered. The strobe, address and data appear the cycle after the accepted beat; the strobe is high for 1 cycle per beat. The final write of a go frame coincides with the cpu_start cycle.
- Write strobes are never asserted outside LOAD-derived cycles. imem_we and dmem_we are never asserted together.
- Reset values: HDR, in_ready=1 (combinational from state), mem_own=1, all strobes, cpu_start, out_valid, out_last and err = 0, out_data=0, addresses and wdata = 0, internal counters 0.
- rst asserted in any state, including mid-frame, RUN or mid-dump: next cycle is in the reset state. Memory contents are not cleared. The partial frame is discarded. A partially streamed dump is abandoned without asserting out_last.
- Input words presented outside HDR/LOAD are not accepted (in_ready=0); the upstream holds them.
- A one-cycle gap between payload beats (in_valid=0) is legal.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants for the loader;
  - header field bit positions;
  - sel encodings MEM_SEL_INSTR=0, MEM_SEL_DATA=1.
- One sub-module: cpu_dump_ctrl, holding the DUMP_RD/DUMP_WAIT/DUMP_OUT sequencer with index counter and out handshake. It is started by a pulse from the main FSM and returns a dump_done pulse.

Test Plan:
- Data frame: header sel=1, go=0, count=8, base=0, payload 5,3,0,0,0,0,0,0 -> eight dmem_we pulses at addresses 0..7 in order; err=0; back in HDR.
- Instruction frame with go: sel=0, go=1, count=8, base=0, payload 0100010000, 0110010100, 1000000101, 1011000110, 1100001011, 1110000000, 1111111110, 0000000000 -> cpu_start pulses once; cpu_top completes; dump yields 10, 3, 8, 11, 247, 2, 253, 20 with out_last only on the 8th word.
- Wrap-around: sel=1, count=3, base=6, payload 1,2,3 -> writes to addresses 6, 7, 0.
- Backpressure on dump: hold out_ready=0 for 5 cycles on word 2 -> out_valid stays high and out_data is stable; no word is skipped or duplicated.
- Malformed header with reserved bit set -> err=1, no memory write; the next valid frame loads normally and err stays 1.
- rst asserted during LOAD after 2 of 4 beats -> next cycle is HDR with all outputs at reset values; the following frame loads correctly.
